data_memory_64b: RTL and testbench

Word-organised 64-bit data memory for the datapath's memory stage: one synchronous write port and one registered read port sharing a single address. It stores 64-bit words indexed by the low bits of a 64-bit address and is gated by a global enable. It sits between the ALU result bus (address) and the write-back mux (read_data).

---
 rtl/data_memory_pkg.sv | 10 +
 rtl/dm_storage.sv | 26 ++
 rtl/data_memory_64b.sv | 65 ++++++
 tb/tb_data_memory_64b.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared constants and types for the 64-bit word-organised data memory.
// The optional write-first bypass is enabled by defining DATA_MEM_BYPASS_EN.
package data_memory_pkg;
  localparam int DM_DATA_W = 64;
  localparam int DM_DEPTH  = 256;
  localparam int DM_IDX_W  = $clog2(DM_DEPTH);

  typedef logic [DM_DATA_W-1:0] word_t;
  typedef logic [DM_IDX_W-1:0]  idx_t;
endpackage

// File: rtl/dm_storage.sv
// Bare DEPTH x DATA_W array: one synchronous write port, one combinational
// read port, no reset (contents survive rst_n).
module dm_storage
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int DEPTH  = DM_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/data_memory_64b.sv
// Memory-stage data memory: shared word address, synchronous write, registered read.
// Define DATA_MEM_BYPASS_EN for write-first same-edge behaviour (default: read-first).
module data_memory_64b
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int DEPTH  = DM_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              E,
  input  logic [63:0]       address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic [DATA_W-1:0] read_data
);
  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] read_data_d;
  logic [DATA_W-1:0] read_data_q;
  logic              unused_addr;

  // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH.
  assign idx         = address[IDX_W-1:0];
  assign unused_addr = ^address[63:IDX_W];

  // rst_n gates the write so a write pending while reset is asserted is dropped.
  assign wr_en = E & mem_write & rst_n;

  dm_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (idx),
    .wdata_i (write_data),
    .raddr_i (idx),
    .rdata_o (rd_word)
  );

  always_comb begin
    read_data_d = read_data_q;
    if (E && mem_read) begin
`ifdef DATA_MEM_BYPASS_EN
      read_data_d = mem_write ? write_data : rd_word;
`else
      read_data_d = rd_word;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;
endmodule

// File: tb/tb_data_memory_64b.sv
// Randomised scoreboard bench for data_memory_64b against an array reference model.
module tb_data_memory_64b;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        E = 1'b0;
  logic [63:0] address = '0;
  logic [63:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [63:0] read_data;

  logic [63:0] model_mem [DEPTH];
  logic [63:0] exp_q [$];
  logic [63:0] hold_exp = '0;
  logic        fire_q = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  data_memory_64b dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .E          (E),
    .address    (address),
    .write_data (write_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .read_data  (read_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: read_data=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: a read sampled at posedge is compared at the following negedge
  always @(posedge clk) fire_q <= rst_n && E && mem_read;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_exp = '0;
      check("reset_hold", read_data, 64'd0);
    end else if (fire_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: read_data=%h required=no read", read_data);
      end else begin
        hold_exp = exp_q.pop_front();
        check("read", read_data, hold_exp);
      end
    end else begin
      check("hold", read_data, hold_exp);
    end
  end

  // driver: apply one cycle of inputs after a negedge and update the model
  task automatic drive(input logic e, input logic we, input logic re,
                       input logic [63:0] addr, input logic [63:0] wd);
    int idx;
    @(negedge clk);
    E = e; mem_write = we; mem_read = re; address = addr; write_data = wd;
    idx = int'(addr % 64'(DEPTH));
    if (rst_n && e && re) begin
`ifdef DATA_MEM_BYPASS_EN
      exp_q.push_back(we ? wd : model_mem[idx]);
`else
      exp_q.push_back(model_mem[idx]);
`endif
    end
    if (rst_n && e && we) model_mem[idx] = wd;
  endtask

  // reset pulse between edges with a write pending; the write must be dropped
  task automatic reset_pulse(input logic [63:0] addr);
    @(negedge clk);
    #2;
    E = 1'b1; mem_read = 1'b1; mem_write = 1'b1; address = addr;
    write_data = {$urandom, $urandom};
    rst_n = 1'b0;
    #1;
    check("reset_async", read_data, 64'd0);
    repeat (2) @(negedge clk);
    #2;
    mem_write = 1'b0; mem_read = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    E = 1'b1; mem_read = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    mem_read = 1'b0;
    rst_n = 1'b1;

    // fill every word so no read ever touches an unwritten location
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 64'(i), {$urandom, $urandom});

    // directed
    drive(1'b1, 1'b1, 1'b0, 64'd23, 64'd48);
    drive(1'b1, 1'b0, 1'b1, 64'd23, 64'd0);
    drive(1'b1, 1'b1, 1'b1, 64'd23, 64'd28);
    drive(1'b1, 1'b0, 1'b1, 64'd23, 64'd0);
    drive(1'b0, 1'b1, 1'b1, 64'd23, 64'd99);
    drive(1'b0, 1'b0, 1'b0, 64'd23, 64'd0);
    drive(1'b1, 1'b0, 1'b1, 64'd23, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 64'd279, 64'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b1, 64'd23, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 64'd23, 64'd28);
    drive(1'b1, 1'b0, 1'b1, 64'd23, 64'd0);
    reset_pulse(64'd23);
    drive(1'b1, 1'b0, 1'b1, 64'd23, 64'd0);
    drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF17, 64'd0);

    // random
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse({$urandom, $urandom});
      end else begin
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
              {$urandom, $urandom});
      end
    end

    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
